gnss_code_nco: RTL and testbench

Parametrised code-rate numerically controlled oscillator for the GPS receiver front end. Runs a phase accumulator at a runtime-programmable frequency control word (nominal 1.023 MHz C/A chip rate, Doppler-adjustable). Emits one-cycle sector-tap pulses at 2^PHASE_BITS evenly spaced phases per chip, plus a chip index and a code-epoch strobe. Sits between the system clock and the PRN code generators and correlator early/prompt/late taps.

---
 rtl/gnss_nco_pkg.sv | 17 +
 rtl/gnss_code_nco_if.sv | 35 +++
 rtl/gnss_chip_counter.sv | 51 +++++
 rtl/gnss_code_nco.sv | 96 +++++++++
 tb/tb_gnss_code_nco.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gnss_nco_pkg.sv
// Shared constants and helpers for the GPS code-rate NCO and the PRN code generators.
package gnss_nco_pkg;

  localparam int CA_CHIPS  = 1023;
  localparam int F_CHIP_HZ = 1_023_000;
  localparam int CA_IDX_W  = $clog2(CA_CHIPS);

  typedef logic [CA_IDX_W-1:0] ca_chip_idx_t;

  // round(2^acc_w * f_out / f_clk)
  function automatic longint unsigned calc_fcw(input int acc_w,
                                               input longint unsigned f_out_hz,
                                               input longint unsigned f_clk_hz);
    return ((f_out_hz << acc_w) + (f_clk_hz >> 1)) / f_clk_hz;
  endfunction

endpackage

// File: rtl/gnss_code_nco_if.sv
// Control and output bundle of the code NCO; master drives control, slave is the NCO.
interface gnss_code_nco_if
  import gnss_nco_pkg::*;
#(
  parameter int ACC_W      = 32,
  parameter int PHASE_BITS = 2,
  parameter int CHIPS      = CA_CHIPS
);
  localparam int NTAP  = 1 << PHASE_BITS;
  localparam int IDX_W = $clog2(CHIPS);

  logic             enable;
  logic             fcw_we;
  logic [ACC_W-1:0] fcw_i;
  logic             sync_i;
  logic [ACC_W-1:0] phase_set_i;
  logic [IDX_W-1:0] chip_set_i;

  logic [NTAP-1:0]  tap_o;
  logic [IDX_W-1:0] chip_idx_o;
  logic             epoch_o;
  logic             skip_err_o;
  logic [ACC_W-1:0] acc_o;

  modport master (
    output enable, fcw_we, fcw_i, sync_i, phase_set_i, chip_set_i,
    input  tap_o, chip_idx_o, epoch_o, skip_err_o, acc_o
  );

  modport slave (
    input  enable, fcw_we, fcw_i, sync_i, phase_set_i, chip_set_i,
    output tap_o, chip_idx_o, epoch_o, skip_err_o, acc_o
  );

endinterface

// File: rtl/gnss_chip_counter.sv
// Modulo-CHIPS chip counter with load, increment and a registered wrap strobe.
module gnss_chip_counter
  import gnss_nco_pkg::*;
#(
  parameter int CHIPS = CA_CHIPS
) (
  input  logic                       clk_in,
  input  logic                       rst,
  input  logic                       load_i,
  input  logic [$clog2(CHIPS)-1:0]   load_val_i,
  input  logic                       inc_i,
  output logic [$clog2(CHIPS)-1:0]   idx_o,
  output logic                       wrap_o
);
  localparam int                IDX_W   = $clog2(CHIPS);
  localparam logic [IDX_W:0]    CHIPS_X = (IDX_W+1)'(CHIPS);
  localparam logic [IDX_W-1:0]  LAST    = IDX_W'(CHIPS-1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (load_i) begin
      // Out-of-range load values fall back to chip 0 rather than an illegal index
      idx_d = ({1'b0, load_val_i} >= CHIPS_X) ? '0 : load_val_i;
    end else if (inc_i) begin
      if (idx_q == LAST) begin
        idx_d  = '0;
        wrap_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      idx_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
    end
  end

  assign idx_o  = idx_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/gnss_code_nco.sv
// Code-rate NCO: phase accumulator emitting sector-entry taps, chip index and epoch strobe.
module gnss_code_nco
  import gnss_nco_pkg::*;
#(
  parameter int               ACC_W       = 32,
  parameter int               PHASE_BITS  = 2,
  parameter int               CHIPS       = CA_CHIPS,
  parameter logic [ACC_W-1:0] FCW_DEFAULT = ACC_W'(calc_fcw(ACC_W, longint'(F_CHIP_HZ), 64'd16_000_000))
) (
  input logic            clk_in,
  input logic            rst,
  gnss_code_nco_if.slave nco
);
  localparam int                   NTAP     = 1 << PHASE_BITS;
  localparam logic [NTAP-1:0]      TAP_ONE  = NTAP'(1);
  localparam logic [PHASE_BITS-1:0] STEP_ONE = PHASE_BITS'(1);

  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [ACC_W-1:0]      fcw_q, fcw_d;
  logic [PHASE_BITS-1:0] prev_q, prev_d;
  logic [NTAP-1:0]       tap_q, tap_d;
  logic                  skip_q, skip_d;

  logic [ACC_W:0]        sum;
  logic                  carry;
  logic [ACC_W-1:0]      nxt;
  logic [PHASE_BITS-1:0] sec;
  logic [PHASE_BITS-1:0] step;
  logic                  chip_inc;

  assign sum   = {1'b0, acc_q} + {1'b0, fcw_q};
  assign carry = sum[ACC_W];
  assign nxt   = sum[ACC_W-1:0];
  assign sec   = nxt[ACC_W-1 -: PHASE_BITS];
  assign step  = sec - prev_q;

  // Chips are counted from the accumulator carry so a skipped sector 0 still advances the chip
  assign chip_inc = nco.enable & ~nco.sync_i & carry;

  always_comb begin
    acc_d  = acc_q;
    fcw_d  = fcw_q;
    prev_d = prev_q;
    tap_d  = '0;
    skip_d = skip_q;
    if (nco.fcw_we) begin
      fcw_d = nco.fcw_i;
    end
    if (nco.sync_i) begin
      acc_d  = nco.phase_set_i;
      prev_d = nco.phase_set_i[ACC_W-1 -: PHASE_BITS];
    end else if (nco.enable) begin
      acc_d  = nxt;
      prev_d = sec;
      if (sec != prev_q) begin
        tap_d = TAP_ONE << sec;
      end
      if (step > STEP_ONE) begin
        skip_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      acc_q  <= '0;
      fcw_q  <= FCW_DEFAULT;
      prev_q <= '0;
      tap_q  <= '0;
      skip_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      fcw_q  <= fcw_d;
      prev_q <= prev_d;
      tap_q  <= tap_d;
      skip_q <= skip_d;
    end
  end

  gnss_chip_counter #(
    .CHIPS (CHIPS)
  ) u_chip_cnt (
    .clk_in     (clk_in),
    .rst        (rst),
    .load_i     (nco.sync_i),
    .load_val_i (nco.chip_set_i),
    .inc_i      (chip_inc),
    .idx_o      (nco.chip_idx_o),
    .wrap_o     (nco.epoch_o)
  );

  assign nco.acc_o      = acc_q;
  assign nco.tap_o      = tap_q;
  assign nco.skip_err_o = skip_q;

endmodule

// File: tb/tb_gnss_code_nco.sv
// Bench for gnss_code_nco: a small 8-bit instance for directed/random cases and a default-parameter instance for long runs.
module tb_gnss_code_nco;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  gnss_code_nco_if #(.ACC_W(8),  .PHASE_BITS(2), .CHIPS(4))    s ();
  gnss_code_nco_if #(.ACC_W(32), .PHASE_BITS(2), .CHIPS(1023)) d ();

  gnss_code_nco #(.ACC_W(8), .PHASE_BITS(2), .CHIPS(4), .FCW_DEFAULT(8'd20)) u_small (
    .clk_in (clk),
    .rst    (rst),
    .nco    (s)
  );

  gnss_code_nco u_dflt (
    .clk_in (clk),
    .rst    (rst),
    .nco    (d)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, index 0 = small instance, 1 = default instance
  int     P_AW [2] = '{8, 32};
  int     P_CH [2] = '{4, 1023};
  longint P_DEF[2] = '{20, 274609471};
  longint m_acc[2], m_prev[2], m_fcw[2], m_chip[2], m_tap[2], m_epoch[2], m_skip[2];

  task automatic model_step(input int dx, input bit r, input bit sy, input bit en, input bit we,
                            input longint fi, input longint ps, input longint cs);
    longint modv, secsz, nx, sec;
    modv  = longint'(1) << P_AW[dx];
    secsz = modv / 4;
    if (r) begin
      m_acc[dx] = 0; m_prev[dx] = 0; m_fcw[dx] = P_DEF[dx]; m_chip[dx] = 0;
      m_tap[dx] = 0; m_epoch[dx] = 0; m_skip[dx] = 0;
      return;
    end
    if (sy) begin
      m_acc[dx]   = ps;
      m_prev[dx]  = ps / secsz;
      m_chip[dx]  = (cs < P_CH[dx]) ? cs : 0;
      m_tap[dx]   = 0;
      m_epoch[dx] = 0;
    end else if (en) begin
      nx  = m_acc[dx] + m_fcw[dx];
      sec = (nx % modv) / secsz;
      m_tap[dx] = (sec != m_prev[dx]) ? (longint'(1) << sec) : 0;
      if (((sec - m_prev[dx] + 4) % 4) > 1) m_skip[dx] = 1;
      m_epoch[dx] = 0;
      if (nx >= modv) begin
        m_chip[dx]  = (m_chip[dx] + 1) % P_CH[dx];
        m_epoch[dx] = (m_chip[dx] == 0) ? 1 : 0;
      end
      m_prev[dx] = sec;
      m_acc[dx]  = nx % modv;
    end else begin
      m_tap[dx]   = 0;
      m_epoch[dx] = 0;
    end
    if (we) m_fcw[dx] = fi;
  endtask

  function automatic logic [15:0] exp_s();
    return {m_acc[0][7:0], m_chip[0][1:0], m_tap[0][3:0], m_epoch[0][0], m_skip[0][0]};
  endfunction

  function automatic logic [47:0] exp_d();
    return {m_acc[1][31:0], m_chip[1][9:0], m_tap[1][3:0], m_epoch[1][0], m_skip[1][0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    model_step(0, rst, s.sync_i, s.enable, s.fcw_we, longint'(s.fcw_i), longint'(s.phase_set_i), longint'(s.chip_set_i));
    model_step(1, rst, d.sync_i, d.enable, d.fcw_we, longint'(d.fcw_i), longint'(d.phase_set_i), longint'(d.chip_set_i));
  endtask

  task automatic idle_inputs();
    s.enable = 0; s.fcw_we = 0; s.fcw_i = '0; s.sync_i = 0; s.phase_set_i = '0; s.chip_set_i = '0;
    d.enable = 0; d.fcw_we = 0; d.fcw_i = '0; d.sync_i = 0; d.phase_set_i = '0; d.chip_set_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic load_fcw_small(input logic [7:0] f);
    s.fcw_we = 1; s.fcw_i = f;
    tick();
    s.fcw_we = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; s.sync_i = 1; s.enable = 1; s.fcw_we = 1; s.fcw_i = 8'd77; s.phase_set_i = 8'hAA;
    d.enable = 1; d.sync_i = 1; d.phase_set_i = 32'h1234_5678;
    tick();
    tick();
    n_checks++;
    if ({s.acc_o, s.chip_idx_o, s.tap_o, s.epoch_o, s.skip_err_o} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_small: got %h required %h", {s.acc_o, s.chip_idx_o, s.tap_o, s.epoch_o, s.skip_err_o}, 16'h0);
    end
    n_checks++;
    if ({d.acc_o, d.chip_idx_o, d.tap_o, d.epoch_o, d.skip_err_o} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_dflt: got %h required %h", {d.acc_o, d.chip_idx_o, d.tap_o, d.epoch_o, d.skip_err_o}, 48'h0);
    end
    rst = 0; idle_inputs();
    s.enable = 1; d.enable = 1;
    tick();
    n_checks++;
    if ({s.acc_o, s.tap_o} !== {8'd20, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_fcw_small: got acc=%0d tap=%b required acc=20 tap=0000", s.acc_o, s.tap_o);
    end
    n_checks++;
    if (d.acc_o !== 32'd274609471) begin
      n_fail++;
      $display("FAIL reset_fcw_dflt: got acc=%0d required 274609471", d.acc_o);
    end
  endtask

  task automatic test_basic();
    logic [15:0] obs, expv;
    do_reset();
    load_fcw_small(8'd16);
    s.enable = 1;
    for (int k = 1; k <= 64; k++) begin
      tick();
      obs  = {s.acc_o, s.chip_idx_o, s.tap_o, s.epoch_o, s.skip_err_o};
      expv = {8'((16*k) % 256), 2'((k/16) % 4), (k % 4 == 0) ? 4'(1 << ((k/4) % 4)) : 4'd0, (k == 64), 1'b0};
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL basic_fcw16 cycle %0d: got %h required %h", k, obs, expv);
      end
    end
  endtask

  task automatic test_fcw_change();
    do_reset();
    load_fcw_small(8'd16);
    s.enable = 1;
    for (int k = 1; k <= 5; k++) tick();
    s.fcw_we = 1; s.fcw_i = 8'd32;
    tick();
    s.fcw_we = 0;
    n_checks++;
    if (s.acc_o !== 8'd96) begin
      n_fail++;
      $display("FAIL fcw_change_old: got acc=%0d required 96", s.acc_o);
    end
    tick();
    n_checks++;
    if ({s.acc_o, s.tap_o} !== {8'd128, 4'b0100}) begin
      n_fail++;
      $display("FAIL fcw_change_new: got acc=%0d tap=%b required acc=128 tap=0100", s.acc_o, s.tap_o);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      n_checks++;
      if ({s.acc_o, s.chip_idx_o, s.tap_o, s.epoch_o, s.skip_err_o} !== exp_s()) begin
        n_fail++;
        $display("FAIL fcw_change_seq %0d: got %h required %h", k, {s.acc_o, s.chip_idx_o, s.tap_o, s.epoch_o, s.skip_err_o}, exp_s());
      end
    end
    n_checks++;
    if (s.skip_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fcw_change_noskip: got %b required 0", s.skip_err_o);
    end
  endtask

  task automatic test_skip();
    do_reset();
    load_fcw_small(8'd130);
    s.enable = 1;
    tick();
    n_checks++;
    if ({s.acc_o, s.tap_o, s.skip_err_o} !== {8'd130, 4'b0100, 1'b1}) begin
      n_fail++;
      $display("FAIL skip_first: got acc=%0d tap=%b skip=%b required acc=130 tap=0100 skip=1", s.acc_o, s.tap_o, s.skip_err_o);
    end
    s.fcw_we = 1; s.fcw_i = 8'd16;
    tick();
    s.fcw_we = 0;
    n_checks++;
    if ({s.acc_o, s.chip_idx_o, s.tap_o} !== {8'd4, 2'd1, 4'b0001}) begin
      n_fail++;
      $display("FAIL skip_carry: got acc=%0d chip=%0d tap=%b required acc=4 chip=1 tap=0001", s.acc_o, s.chip_idx_o, s.tap_o);
    end
    for (int k = 0; k < 8; k++) tick();
    n_checks++;
    if ({s.acc_o, s.skip_err_o} !== {8'd132, 1'b1}) begin
      n_fail++;
      $display("FAIL skip_sticky: got acc=%0d skip=%b required acc=132 skip=1", s.acc_o, s.skip_err_o);
    end
  endtask

  task automatic test_sync();
    do_reset();
    load_fcw_small(8'd16);
    s.enable = 1;
    for (int k = 0; k < 5; k++) tick();
    s.sync_i = 1; s.phase_set_i = 8'h3C; s.chip_set_i = 2'd3;
    tick();
    s.sync_i = 0;
    n_checks++;
    if ({s.acc_o, s.chip_idx_o, s.tap_o, s.epoch_o} !== {8'h3C, 2'd3, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL sync_load: got acc=%h chip=%0d tap=%b ep=%b required acc=3c chip=3 tap=0000 ep=0", s.acc_o, s.chip_idx_o, s.tap_o, s.epoch_o);
    end
    tick();
    n_checks++;
    if ({s.acc_o, s.chip_idx_o, s.tap_o} !== {8'h4C, 2'd3, 4'b0010}) begin
      n_fail++;
      $display("FAIL sync_next: got acc=%h chip=%0d tap=%b required acc=4c chip=3 tap=0010", s.acc_o, s.chip_idx_o, s.tap_o);
    end
    for (int k = 0; k < 15; k++) begin
      tick();
      n_checks++;
      if ({s.acc_o, s.chip_idx_o, s.tap_o, s.epoch_o, s.skip_err_o} !== exp_s()) begin
        n_fail++;
        $display("FAIL sync_seq %0d: got %h required %h", k, {s.acc_o, s.chip_idx_o, s.tap_o, s.epoch_o, s.skip_err_o}, exp_s());
      end
    end
    s.enable = 0;
    // Default instance: out-of-range chip load, then a wrap from the last chip
    d.sync_i = 1; d.phase_set_i = 32'h8000_0000; d.chip_set_i = 10'd1023;
    tick();
    n_checks++;
    if (d.chip_idx_o !== 10'd0) begin
      n_fail++;
      $display("FAIL sync_chip_oob: got %0d required 0", d.chip_idx_o);
    end
    d.phase_set_i = 32'hFFFF_FFF0; d.chip_set_i = 10'd1022;
    tick();
    d.sync_i = 0; d.enable = 1;
    tick();
    d.enable = 0;
    n_checks++;
    if ({d.chip_idx_o, d.epoch_o, d.tap_o} !== {10'd0, 1'b1, 4'b0001}) begin
      n_fail++;
      $display("FAIL sync_epoch_wrap: got chip=%0d ep=%b tap=%b required chip=0 ep=1 tap=0001", d.chip_idx_o, d.epoch_o, d.tap_o);
    end
  endtask

  task automatic test_hold();
    do_reset();
    load_fcw_small(8'd16);
    s.enable = 1;
    for (int k = 0; k < 6; k++) tick();
    s.enable = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++;
      if ({s.acc_o, s.tap_o, s.epoch_o} !== {8'd96, 4'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL hold_frozen %0d: got acc=%0d tap=%b ep=%b required acc=96 tap=0000 ep=0", k, s.acc_o, s.tap_o, s.epoch_o);
      end
    end
    s.enable = 1;
    tick();
    tick();
    n_checks++;
    if ({s.acc_o, s.tap_o} !== {8'd128, 4'b0100}) begin
      n_fail++;
      $display("FAIL hold_resume: got acc=%0d tap=%b required acc=128 tap=0100", s.acc_o, s.tap_o);
    end
    rst = 1; s.sync_i = 1; s.phase_set_i = 8'h3C; s.chip_set_i = 2'd2; s.fcw_we = 1; s.fcw_i = 8'd99;
    tick();
    rst = 0; s.sync_i = 0; s.fcw_we = 0;
    n_checks++;
    if ({s.acc_o, s.chip_idx_o, s.tap_o, s.epoch_o, s.skip_err_o} !== 16'h0) begin
      n_fail++;
      $display("FAIL hold_rst_sync: got %h required 0000", {s.acc_o, s.chip_idx_o, s.tap_o, s.epoch_o, s.skip_err_o});
    end
    tick();
    n_checks++;
    if (s.acc_o !== 8'd20) begin
      n_fail++;
      $display("FAIL hold_rst_fcw: got acc=%0d required 20", s.acc_o);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rst           = ($urandom_range(0, 199) == 0);
      s.sync_i      = ($urandom_range(0, 19) == 0);
      s.enable      = ($urandom_range(0, 3) != 0);
      s.fcw_we      = ($urandom_range(0, 9) == 0);
      s.fcw_i       = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(1, 64));
      s.phase_set_i = 8'($urandom);
      s.chip_set_i  = 2'($urandom);
      tick();
      n_checks++;
      if ({s.acc_o, s.chip_idx_o, s.tap_o, s.epoch_o, s.skip_err_o} !== exp_s()) begin
        n_fail++;
        $display("FAIL random %0d: got %h required %h", k, {s.acc_o, s.chip_idx_o, s.tap_o, s.epoch_o, s.skip_err_o}, exp_s());
      end
    end
    rst = 0;
    idle_inputs();
  endtask

  task automatic test_default_long();
    int     n_cyc;
    int     epochs;
    int     next_sec;
    longint exp_epochs;
    n_cyc    = 48500;
    epochs   = 0;
    next_sec = 1;
    do_reset();
    d.enable = 1;
    for (int k = 0; k < n_cyc; k++) begin
      tick();
      n_checks++;
      if ({d.acc_o, d.chip_idx_o, d.tap_o, d.epoch_o, d.skip_err_o} !== exp_d()) begin
        n_fail++;
        $display("FAIL dflt_seq %0d: got %h required %h", k, {d.acc_o, d.chip_idx_o, d.tap_o, d.epoch_o, d.skip_err_o}, exp_d());
      end
      if (d.tap_o !== 4'd0) begin
        n_checks++;
        if (d.tap_o !== 4'(1 << next_sec)) begin
          n_fail++;
          $display("FAIL dflt_tap_order %0d: got %b required %b", k, d.tap_o, 4'(1 << next_sec));
        end
        next_sec = (next_sec + 1) % 4;
      end
      if (d.epoch_o === 1'b1) epochs++;
    end
    d.enable = 0;
    exp_epochs = (longint'(n_cyc) * 64'd274609471) / ((longint'(1) << 32) * 1023);
    n_checks++;
    if (longint'(epochs) !== exp_epochs) begin
      n_fail++;
      $display("FAIL dflt_epochs: got %0d required %0d", epochs, exp_epochs);
    end
    n_checks++;
    if (d.skip_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL dflt_noskip: got %b required 0", d.skip_err_o);
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_basic();
    test_fcw_change();
    test_skip();
    test_sync();
    test_hold();
    test_random();
    test_default_long();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
